// File: rtl/lza_lod_correct_pkg.sv
// Shared constants and types for the LZA leading-one detect / correction stage.
package lza_pkg;

  localparam int W_DEF   = 56;
  localparam int SHW_DEF = 6;

  // Operating modes carried on cont; any other encoding is passed through as unsupported.
  localparam logic [2:0] MODE_DBL  = 3'b000;
  localparam logic [2:0] MODE_DUAL = 3'b001;
  localparam logic [2:0] MODE_EXT  = 3'b010;

  // Lane boundaries (bit indices into the W-wide vectors).
  localparam int HI_MSB      = 55;
  localparam int DBL_LSB     = 6;
  localparam int EXT_LSB     = 8;
  localparam int DUAL_HI_LSB = 32;
  localparam int DUAL_LO_MSB = 23;
  localparam int DUAL_LO_LSB = 0;

  // Per-lane result handed to the normalization shifter.
  typedef struct packed {
    logic [SHW_DEF-1:0] shamt;
    logic               corr;
    logic               zero;
  } lane_res_t;

  // Contiguous mask with ones from msb down to lsb inclusive.
  function automatic logic [W_DEF-1:0] range_mask(input int msb, input int lsb);
    logic [W_DEF-1:0] m;
    for (int i = 0; i < W_DEF; i++) begin
      m[i] = (i <= msb) && (i >= lsb);
    end
    return m;
  endfunction

endpackage

// File: rtl/lza_lod_correct_if.sv
// Beat interface of the LZA stage: precoded input beat in, per-lane shift result out.
interface lza_lod_correct_if #(
  parameter int W   = 56,
  parameter int SHW = 6
);
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     cont;
  logic [W-1:0]   F;
  logic [W-1:0]   GP_p;
  logic [W-1:0]   GP_n;
  logic [W-1:0]   GN_p;
  logic [W-1:0]   GN_n;
  logic           neg_h;
  logic           neg_l;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_cont;
  logic [SHW-1:0] shamt_h;
  logic [SHW-1:0] shamt_l;
  logic           corr_h;
  logic           corr_l;
  logic           zero_h;
  logic           zero_l;

  // Producer of input beats and consumer of results.
  modport master (
    output in_valid, cont, F, GP_p, GP_n, GN_p, GN_n, neg_h, neg_l, out_ready,
    input  in_ready, out_valid, out_cont, shamt_h, shamt_l, corr_h, corr_l, zero_h, zero_l
  );

  // The LZA stage itself.
  modport slave (
    input  in_valid, cont, F, GP_p, GP_n, GN_p, GN_n, neg_h, neg_l, out_ready,
    output in_ready, out_valid, out_cont, shamt_h, shamt_l, corr_h, corr_l, zero_h, zero_l
  );
endinterface

// File: rtl/lza_lod_correct_lane.sv
// One lane of leading-one detection plus the one-bit correction scan.
// The lane MSB is bit LW-1; inputs are already masked to the lane.
module lza_lane_lod #(
  parameter int LW  = 56,
  parameter int SHW = 6
) (
  input  logic [LW-1:0]  f_i,
  input  logic [LW-1:0]  sel_p_i,
  input  logic [LW-1:0]  sel_n_i,
  output logic [SHW-1:0] shamt_o,
  output logic           corr_o,
  output logic           zero_o
);
  logic           has_f;
  logic           has_p;
  logic           hit_n;
  logic [SHW-1:0] q;
  logic [SHW-1:0] pp;

  // Highest set index of F and of the positive correction digits (later hits override).
  always_comb begin
    has_f = 1'b0;
    q     = '0;
    has_p = 1'b0;
    pp    = '0;
    for (int i = 0; i < LW; i++) begin
      if (f_i[i]) begin
        has_f = 1'b1;
        q     = SHW'(i);
      end
      if (sel_p_i[i]) begin
        has_p = 1'b1;
        pp    = SHW'(i);
      end
    end
  end

  // The highest nonzero digit strictly below p' decides: a negative digit means one short.
  always_comb begin
    hit_n = 1'b0;
    for (int j = 0; j < LW; j++) begin
      if (has_p && (j < int'(pp)) && (sel_p_i[j] || sel_n_i[j])) begin
        hit_n = sel_n_i[j];
      end
    end
  end

  assign shamt_o = has_f ? (SHW'(LW - 1) - q) : '0;
  assign corr_o  = has_f & hit_n;
  assign zero_o  = ~has_f;

endmodule

// File: rtl/lza_lod_correct.sv
// Two-stage LZA leading-one detect with correction flag, feeding the normalization shifter.
// Stage 1 registers the lane-masked vectors; stage 2 registers per-lane shift results.
module lza_lod_correct
  import lza_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int SHW = SHW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  lza_lod_correct_if.slave lza_if
);
  localparam int LO_W = DUAL_LO_MSB + 1;

  // Active-lane mask for a given mode; unsupported modes see no active bits.
  function automatic logic [W-1:0] lane_mask(input logic [2:0] c);
    logic [W-1:0] m;
    case (c)
      MODE_DBL:  m = range_mask(HI_MSB, DBL_LSB);
      MODE_DUAL: m = range_mask(HI_MSB, DUAL_HI_LSB) | range_mask(DUAL_LO_MSB, DUAL_LO_LSB);
      MODE_EXT:  m = range_mask(HI_MSB, EXT_LSB);
      default:   m = '0;
    endcase
    return m;
  endfunction

  logic s1_acc, s2_acc, ld_p1, ld_p2;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;

  logic [W-1:0] mask_p1;
  logic [W-1:0] f_p1_d, gpp_p1_d, gpn_p1_d, gnp_p1_d, gnn_p1_d;
  logic [W-1:0] f_p1_q, gpp_p1_q, gpn_p1_q, gnp_p1_q, gnn_p1_q;
  logic [2:0]   cont_p1_q;
  logic         neg_h_p1_q, neg_l_p1_q;

  logic [W-1:0]    hi_keep, hi_f, hi_sp, hi_sn;
  logic [LO_W-1:0] lo_f, lo_sp, lo_sn;
  logic [SHW-1:0]  hi_shamt, lo_shamt;
  logic            hi_corr, hi_zero, lo_corr, lo_zero;

  lane_res_t  hi_res_d, lo_res_d, hi_res_q, lo_res_q;
  logic [2:0] cont_p2_q;

  // Handshake: each stage accepts when empty or when the stage after it accepts.
  always_comb begin
    s2_acc   = ~vld_p2_q | lza_if.out_ready;
    s1_acc   = ~vld_p1_q | s2_acc;
    ld_p1    = s1_acc & lza_if.in_valid;
    ld_p2    = s2_acc & vld_p1_q;
    vld_p1_d = s1_acc ? lza_if.in_valid : vld_p1_q;
    vld_p2_d = s2_acc ? vld_p1_q : vld_p2_q;
  end

  assign lza_if.in_ready = s1_acc;

  // Valid bits; reset drops any beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 0 -> 1: mask vectors to the active lane(s) ----
  always_comb begin
    mask_p1  = lane_mask(lza_if.cont);
    f_p1_d   = lza_if.F    & mask_p1;
    gpp_p1_d = lza_if.GP_p & mask_p1;
    gpn_p1_d = lza_if.GP_n & mask_p1;
    gnp_p1_d = lza_if.GN_p & mask_p1;
    gnn_p1_d = lza_if.GN_n & mask_p1;
  end

  // Stage-1 data registers load only on an accepted beat.
  always_ff @(posedge clk) begin
    if (ld_p1) begin
      f_p1_q     <= f_p1_d;
      gpp_p1_q   <= gpp_p1_d;
      gpn_p1_q   <= gpn_p1_d;
      gnp_p1_q   <= gnp_p1_d;
      gnn_p1_q   <= gnn_p1_d;
      cont_p1_q  <= lza_if.cont;
      neg_h_p1_q <= lza_if.neg_h;
      neg_l_p1_q <= lza_if.neg_l;
    end
  end

  // ---- stage 1 -> 2: per-lane detection and mode muxing ----
  always_comb begin
    hi_keep = (cont_p1_q == MODE_DUAL) ? range_mask(HI_MSB, DUAL_HI_LSB) : '1;
    hi_f    = f_p1_q & hi_keep;
    hi_sp   = (neg_h_p1_q ? gnp_p1_q : gpp_p1_q) & hi_keep;
    hi_sn   = (neg_h_p1_q ? gnn_p1_q : gpn_p1_q) & hi_keep;
    lo_f    = f_p1_q[LO_W-1:0];
    lo_sp   = neg_l_p1_q ? gnp_p1_q[LO_W-1:0] : gpp_p1_q[LO_W-1:0];
    lo_sn   = neg_l_p1_q ? gnn_p1_q[LO_W-1:0] : gpn_p1_q[LO_W-1:0];
  end

  lza_lane_lod #(.LW(W), .SHW(SHW)) u_lane_hi (
    .f_i     (hi_f),
    .sel_p_i (hi_sp),
    .sel_n_i (hi_sn),
    .shamt_o (hi_shamt),
    .corr_o  (hi_corr),
    .zero_o  (hi_zero)
  );

  lza_lane_lod #(.LW(LO_W), .SHW(SHW)) u_lane_lo (
    .f_i     (lo_f),
    .sel_p_i (lo_sp),
    .sel_n_i (lo_sn),
    .shamt_o (lo_shamt),
    .corr_o  (lo_corr),
    .zero_o  (lo_zero)
  );

  // Select which lane results are live for the beat's mode; idle lanes report zero.
  always_comb begin
    hi_res_d = '{shamt: '0, corr: 1'b0, zero: 1'b1};
    lo_res_d = '{shamt: '0, corr: 1'b0, zero: 1'b1};
    case (cont_p1_q)
      MODE_DBL, MODE_EXT: begin
        hi_res_d = '{shamt: hi_shamt, corr: hi_corr, zero: hi_zero};
      end
      MODE_DUAL: begin
        hi_res_d = '{shamt: hi_shamt, corr: hi_corr, zero: hi_zero};
        lo_res_d = '{shamt: lo_shamt, corr: lo_corr, zero: lo_zero};
      end
      default: ;
    endcase
  end

  // Output registers: cleared by reset, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_res_q  <= '0;
      lo_res_q  <= '0;
      cont_p2_q <= '0;
    end else if (ld_p2) begin
      hi_res_q  <= hi_res_d;
      lo_res_q  <= lo_res_d;
      cont_p2_q <= cont_p1_q;
    end
  end

  assign lza_if.out_valid = vld_p2_q;
  assign lza_if.out_cont  = cont_p2_q;
  assign lza_if.shamt_h   = hi_res_q.shamt;
  assign lza_if.corr_h    = hi_res_q.corr;
  assign lza_if.zero_h    = hi_res_q.zero;
  assign lza_if.shamt_l   = lo_res_q.shamt;
  assign lza_if.corr_l    = lo_res_q.corr;
  assign lza_if.zero_l    = lo_res_q.zero;

endmodule
